// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-outstanding req/ack data bus, store lane
// encoding, load lane extraction with sign/zero extension, ALU pass-through.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func3,
  input  logic [DATA_W-1:0] i_result,
  input  logic [DATA_W-1:0] i_data_store,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata
);

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [29:0] word_addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic [2:0]  func3_reg;
  logic [1:0]  off_reg;
  logic        valid_reg, valid_next;
  logic [31:0] result_reg, result_next;
  logic        misalign_reg, misalign_next;
  logic        bus_err_reg, bus_err_next;

  logic        is_ld, is_st, is_mem, func_legal, addr_misalign, access_ok;
  logic        accept, timeout_hit;
  logic [1:0]  a;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_val;
  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode and legality of the incoming EX result
  assign is_ld  = (i_opcode == OP_LD);
  assign is_st  = (i_opcode == OP_ST);
  assign is_mem = i_valid & (is_ld | is_st);
  assign a      = i_result[1:0];

  always_comb begin
    func_legal = 1'b0;
    if (is_ld)
      func_legal = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010) |
                   (i_func3 == 3'b100) | (i_func3 == 3'b101);
    else if (is_st)
      func_legal = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010);
  end

  assign addr_misalign = ((i_func3[1:0] == 2'b01) & a[0]) |
                         ((i_func3[1:0] == 2'b10) & (a != 2'b00));
  assign access_ok   = func_legal & ~addr_misalign;
  assign accept      = (state_reg == IDLE) & is_mem & access_ok;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign o_stall     = accept | (state_reg == REQ);

  // Store lane encoding; loads reuse be_calc for the access width
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = i_data_store;
    case (i_func3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << a;
        wdata_calc = {4{i_data_store[7:0]}};
      end
      2'b01: begin
        be_calc    = a[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{i_data_store[15:0]}};
      end
      default: ;
    endcase
    if (!is_st)
      wdata_calc = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = i_dmem_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_byte[off_reg];
  assign half_sel = off_reg[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    case (func3_reg)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = i_dmem_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ:  if (i_dmem_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: result pulses; ack wins over timeout in the last cycle
  always_comb begin
    valid_next    = 1'b0;
    result_next   = '0;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_valid && !(is_ld || is_st)) begin
          valid_next  = 1'b1;
          result_next = i_result;
        end else if (is_mem && !access_ok) begin
          valid_next    = 1'b1;
          misalign_next = 1'b1;
        end
      end
      REQ: begin
        if (i_dmem_ack) begin
          valid_next  = 1'b1;
          result_next = we_reg ? 32'h0 : load_val;
        end else if (timeout_hit) begin
          valid_next   = 1'b1;
          bus_err_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      word_addr_reg <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      func3_reg     <= '0;
      off_reg       <= '0;
      valid_reg     <= 1'b0;
      result_reg    <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      result_reg   <= result_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
      if (state_reg == REQ && state_next == REQ)
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;
      if (accept) begin
        word_addr_reg <= i_result[31:2];
        be_reg        <= be_calc;
        wdata_reg     <= wdata_calc;
        we_reg        <= is_st;
        func3_reg     <= i_func3;
        off_reg       <= a;
      end
    end
  end

  assign o_valid      = valid_reg;
  assign o_result     = result_reg;
  assign o_misalign   = misalign_reg;
  assign o_bus_err    = bus_err_reg;
  assign o_dmem_req   = (state_reg == REQ);
  assign o_dmem_we    = we_reg;
  assign o_dmem_addr  = {word_addr_reg, 2'b00};
  assign o_dmem_be    = be_reg;
  assign o_dmem_wdata = wdata_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit consuming the EX-stage outputs: ALU result (address or value), store data, func3 and opcode.
- Drives a single-outstanding req/ack data-memory bus. For stores it generates byte enables and lane-replicated write data. For loads it extracts the addressed lanes and sign- or zero-extends them.
- Non-memory results pass through with one register stage. Upstream is stalled while a memory access is in flight.

Parameters:
- TIMEOUT, 16: cycles to wait for i_dmem_ack before aborting with a bus error (must be >= 1).
- DATA_W, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  EX outputs valid this cycle
- i_opcode  in  7  instruction opcode (LD = 7'b0000011, S = 7'b0100011)
- i_func3  in  3  access width/sign
- i_result  in  32  EX result: effective address for LD/S, otherwise the value to forward
- i_data_store  in  32  rs2 data for stores
- o_stall  out  1  hold upstream inputs stable (combinational)
- o_valid  out  1  one-cycle pulse: o_result/flags valid
- o_result  out  32  writeback value
- o_misalign  out  1  misaligned or illegal-width access, qualified by o_valid
- o_bus_err  out  1  ack timeout, qualified by o_valid
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word address {addr[31:2], 2'b00}
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  write data
- i_dmem_ack  in  1  request complete; rdata valid on loads
- i_dmem_rdata  in  32  read data

Behaviour:
- Reset (rst high at an edge): state IDLE, timeout counter 0, all outputs 0.
  - Reset mid-access drops o_dmem_req at the next edge.
  - A late ack arriving while IDLE is ignored.
- Decode:
  - is_mem = i_valid & (opcode LD or S).
  - Legal load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store func3: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal and treated as misaligned.
  - Halfword accesses require addr[0] = 0. Word accesses require addr[1:0] = 0.
- FSM states: IDLE, REQ.
  - IDLE, non-memory op with i_valid: next edge o_valid = 1, o_result = i_result. Latency 1. No stall.
  - IDLE, is_mem and misaligned/illegal: no bus activity. Next edge o_valid = 1, o_misalign = 1, o_result = 0.
  - IDLE, is_mem and legal: register addr, be, wdata, we, func3 and addr[1:0]; go to REQ with o_dmem_req = 1.
    - o_stall = 1 combinationally in the accept cycle.
- REQ:
  - o_dmem_req, addr, be, wdata and we are held stable. o_stall = 1. The counter increments every cycle.
  - i_dmem_ack = 1: next edge returns to IDLE, req = 0, o_valid = 1.
    - Load: o_result = extracted and extended data.
    - Store: o_result = 0.
    - Minimum memory latency is 2 cycles, accept to o_valid.
  - Counter reaches TIMEOUT - 1 with no ack: next edge returns to IDLE, req = 0, o_valid = 1, o_bus_err = 1, o_result = 0.
  - Ack in that same last cycle takes priority over timeout.
- Store encoding (a = addr[1:0]):
  - SB: be = 4'b0001 << a, wdata = {4{rs2[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Load extraction (a = registered offset):
  - Byte = rdata[8a+7 : 8a]. Halfword = rdata[16a[1]+15 : 16a[1]].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW returns rdata unchanged.
  - o_dmem_be reflects the access width. o_dmem_we = 0.
- o_valid, o_misalign and o_bus_err are single-cycle pulses. All three are 0 in every other cycle.
- i_valid during REQ is ignored; upstream is stalled and holds its inputs.

Test Plan:
- ALU forward: opcode R, i_result = 32'h4444_5555, i_valid one cycle -> next cycle o_valid = 1, o_result = 32'h4444_5555, o_stall never high, no o_dmem_req.
- LB sign-extend: addr 32'h0000_0009, func3 000, ack 3 cycles after req with rdata 32'h1122_8344 -> o_dmem_addr = 32'h0000_0008, be = 4'b0010, o_result = 32'hFFFF_FF83, o_stall held until ack; LBU on the same data -> 32'h0000_0083.
- SH upper half: addr 32'h0000_0106, rs2 = 32'hABCD_1234, ack same cycle as req -> o_dmem_we = 1, be = 4'b1100, wdata = 32'h1234_1234, o_valid 2 cycles after accept, o_result = 0.
- Misaligned/illegal: LW at addr 32'h0000_0002, then LD with func3 011 at addr 32'h0000_0008 -> each yields o_valid = 1 and o_misalign = 1 one cycle later, o_dmem_req stays 0.
- Timeout: SW with TIMEOUT = 16 and no ack -> req high exactly 16 cycles, then o_valid = 1, o_bus_err = 1, o_result = 0, state IDLE; a late ack is ignored.
- Reset mid-access: assert rst during REQ -> req, o_stall and o_valid are 0 after the edge; the next LW after reset completes normally.
